alu_seq: RTL and testbench

- Parametrised, clocked successor to the project's combinational ALU.
- Adds the following over the combinational ALU:
  - registered result with a persistent Carry flag, plus ADC/SBB for multi-word arithmetic
  - variable-amount shifts, executed one bit per cycle
  - iterative unsigned shift-add multiply with a 2W-bit product
  - Start/Busy/Done handshake
- Sits between the register file read ports and the writeback mux. The controller stalls on Busy and writes back on Done.

---
 rtl/alu_seq.sv | 197 +++++++++++++++++++
 tb/tb_alu_seq.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Clocked ALU with a persistent carry flag, multi-word add/subtract, bit-serial shifts
// and an iterative shift-add multiply, using a Start/Busy/Done handshake.
module alu_seq #(
  parameter int W   = 8,
  parameter int Ops = 4,
  parameter int SA  = $clog2(W)
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           Start,
  input  logic [Ops-1:0] OP,
  input  logic [W-1:0]   InputA,
  input  logic [W-1:0]   InputB,
  input  logic           SC_in,
  output logic [W-1:0]   Out,
  output logic [W-1:0]   OutHi,
  output logic           Carry,
  output logic           Zero,
  output logic           Parity,
  output logic           Odd,
  output logic           Busy,
  output logic           Done,
  output logic           Illegal,
  output logic           dbg_state
);

  // Handshake: Start is sampled only on an edge where Busy=0. Busy=1 means an op is in
  // RUN and Start is ignored. Done is a one-cycle pulse in the cycle after the result is
  // written; Start may be raised in that same cycle and is accepted with no bubble.

  localparam logic [Ops-1:0] OP_ADD = Ops'(0);
  localparam logic [Ops-1:0] OP_ADC = Ops'(1);
  localparam logic [Ops-1:0] OP_SUB = Ops'(2);
  localparam logic [Ops-1:0] OP_SBB = Ops'(3);
  localparam logic [Ops-1:0] OP_LSH = Ops'(4);
  localparam logic [Ops-1:0] OP_RSH = Ops'(5);
  localparam logic [Ops-1:0] OP_ASR = Ops'(6);
  localparam logic [Ops-1:0] OP_XOR = Ops'(7);
  localparam logic [Ops-1:0] OP_AND = Ops'(8);
  localparam logic [Ops-1:0] OP_OR  = Ops'(9);
  localparam logic [Ops-1:0] OP_MUL = Ops'(10);
  localparam logic [Ops-1:0] OP_CLC = Ops'(11);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state;
  logic [Ops-1:0] op_q;
  logic [W-1:0]   a_q;
  logic           sc_q;
  logic [SA:0]    cnt;
  logic [W-1:0]   sh;
  logic [2*W-1:0] prod;
  logic           mul_last;

  logic [W-1:0]   b_eff;
  logic           cin;
  logic [W:0]     sum;
  logic [SA-1:0]  k;
  logic [W-1:0]   sh_next;
  logic [W:0]     mul_sum;
  logic [2*W-1:0] prod_next;

  assign dbg_state = state;
  assign k         = InputB[SA-1:0];

  always_comb begin
    b_eff = ((OP == OP_SUB) || (OP == OP_SBB)) ? ~InputB : InputB;
    cin   = 1'b0;
    case (OP)
      OP_ADC, OP_SBB: cin = Carry;
      OP_SUB:         cin = 1'b1;
      default:        cin = 1'b0;
    endcase
    sum = {1'b0, InputA} + {1'b0, b_eff} + {{W{1'b0}}, cin};
  end

  // One shift step per RUN cycle; LSH fills from the SC_in captured at acceptance.
  always_comb begin
    sh_next = sh;
    case (op_q)
      OP_LSH:  sh_next = {sh[W-2:0], sc_q};
      OP_RSH:  sh_next = {1'b0, sh[W-1:1]};
      OP_ASR:  sh_next = {sh[W-1], sh[W-1:1]};
      default: sh_next = sh;
    endcase
  end

  // Multiplier in the low half is consumed LSB first while partial sums enter the top.
  always_comb begin
    mul_sum   = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, a_q} : {(W+1){1'b0}});
    prod_next = {mul_sum, prod[W-1:1]};
  end

  assign Zero   = mul_last ? ~|{OutHi, Out} : ~|Out;
  assign Parity = ^Out;
  assign Odd    = Out[0];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      sc_q     <= 1'b0;
      cnt      <= '0;
      sh       <= '0;
      prod     <= '0;
      mul_last <= 1'b0;
      Out      <= '0;
      OutHi    <= '0;
      Carry    <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Illegal  <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            op_q <= OP;
            a_q  <= InputA;
            sc_q <= SC_in;
            case (OP)
              OP_ADD, OP_ADC, OP_SUB, OP_SBB: begin
                Out      <= sum[W-1:0];
                OutHi    <= '0;
                Carry    <= sum[W];
                mul_last <= 1'b0;
                Illegal  <= 1'b0;
                Done     <= 1'b1;
              end
              OP_LSH, OP_RSH, OP_ASR: begin
                if (k == '0) begin
                  Out      <= InputA;
                  OutHi    <= '0;
                  mul_last <= 1'b0;
                  Illegal  <= 1'b0;
                  Done     <= 1'b1;
                end else begin
                  sh    <= InputA;
                  cnt   <= {1'b0, k};
                  Busy  <= 1'b1;
                  state <= RUN;
                end
              end
              OP_XOR, OP_AND, OP_OR: begin
                if (OP == OP_XOR)      Out <= InputA ^ InputB;
                else if (OP == OP_AND) Out <= InputA & InputB;
                else                   Out <= InputA | InputB;
                OutHi    <= '0;
                mul_last <= 1'b0;
                Illegal  <= 1'b0;
                Done     <= 1'b1;
              end
              OP_MUL: begin
                prod  <= {{W{1'b0}}, InputB};
                cnt   <= (SA+1)'(W);
                Busy  <= 1'b1;
                state <= RUN;
              end
              OP_CLC: begin
                Carry   <= 1'b0;
                Illegal <= 1'b0;
                Done    <= 1'b1;
              end
              default: begin
                Illegal <= 1'b1;
                Done    <= 1'b1;
              end
            endcase
          end
        end
        RUN: begin
          sh   <= sh_next;
          prod <= prod_next;
          cnt  <= cnt - 1'b1;
          // The last iteration writes its own result straight to the outputs.
          if (cnt == (SA+1)'(1)) begin
            state   <= IDLE;
            Busy    <= 1'b0;
            Done    <= 1'b1;
            Illegal <= 1'b0;
            if (op_q == OP_MUL) begin
              Out      <= prod_next[W-1:0];
              OutHi    <= prod_next[2*W-1:W];
              mul_last <= 1'b1;
            end else begin
              Out      <= sh_next;
              OutHi    <= '0;
              mul_last <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (W=8): arithmetic with carry chaining, shifts, multiply,
// handshake timing, async reset abort and illegal opcode handling.
module tb_alu_seq;

  logic       Clk, Reset, Start, SC_in;
  logic [3:0] OP;
  logic [7:0] InputA, InputB;
  logic [7:0] Out, OutHi;
  logic       Carry, Zero, Parity, Odd, Busy, Done, Illegal, dbg_state;

  int checks   = 0;
  int failures = 0;

  alu_seq #(.W(8), .Ops(4)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .OP(OP), .InputA(InputA), .InputB(InputB),
    .SC_in(SC_in), .Out(Out), .OutHi(OutHi), .Carry(Carry), .Zero(Zero), .Parity(Parity),
    .Odd(Odd), .Busy(Busy), .Done(Done), .Illegal(Illegal), .dbg_state(dbg_state)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where Done is seen.
  // lat counts negedges after the accepting edge, busy_n counts those with Busy=1.
  task automatic do_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic sc, output int lat, output int busy_n);
    OP = op; InputA = a; InputB = b; SC_in = sc; Start = 1'b1;
    lat = 0; busy_n = 0;
    do begin
      @(negedge Clk);
      lat++;
      Start = 1'b0;
      if (Busy) busy_n++;
    end while (!Done && lat < 40);
    check("done_seen", Done, 1'b1);
  endtask

  int   lat, busy_n, n;
  logic out_ok, seen;

  initial begin
    Reset = 1'b1; Start = 1'b0; OP = '0; InputA = '0; InputB = '0; SC_in = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    check("rst_out", Out, 8'h00);
    check("rst_outhi", OutHi, 8'h00);
    check("rst_carry", Carry, 1'b0);
    check("rst_busy", Busy, 1'b0);
    check("rst_done", Done, 1'b0);
    check("rst_illegal", Illegal, 1'b0);
    check("rst_zero", Zero, 1'b1);
    @(negedge Clk);

    // ADD then ADC chaining the carry
    do_op(4'd0, 8'd200, 8'd100, 1'b0, lat, busy_n);
    check("add_lat", lat, 1);
    check("add_out", Out, 8'd44);
    check("add_carry", Carry, 1'b1);
    do_op(4'd1, 8'd0, 8'd0, 1'b0, lat, busy_n);
    check("adc_out", Out, 8'd1);
    check("adc_carry", Carry, 1'b0);

    // subtract family
    do_op(4'd2, 8'd5, 8'd7, 1'b0, lat, busy_n);
    check("sub_out", Out, 8'hFE);
    check("sub_carry", Carry, 1'b0);
    do_op(4'd3, 8'd10, 8'd3, 1'b0, lat, busy_n);
    check("sbb_out", Out, 8'd6);
    check("sbb_carry", Carry, 1'b1);
    do_op(4'd2, 8'd7, 8'd7, 1'b0, lat, busy_n);
    check("sub0_out", Out, 8'd0);
    check("sub0_zero", Zero, 1'b1);
    check("sub0_carry", Carry, 1'b1);

    // MUL 255x255 with an ADD Start pulsed mid-RUN
    OP = 4'd10; InputA = 8'd255; InputB = 8'd255; Start = 1'b1;
    n = 0; busy_n = 0; out_ok = 1'b1;
    do begin
      @(negedge Clk);
      n++;
      Start = 1'b0;
      if (n == 3) begin
        Start = 1'b1; OP = 4'd0; InputA = 8'd1; InputB = 8'd1;
      end
      if (Busy) begin
        busy_n++;
        if (Out !== 8'd0 || OutHi !== 8'd0) out_ok = 1'b0;
      end
    end while (!Done && n < 40);
    Start = 1'b0;
    check("mul_done_seen", Done, 1'b1);
    check("mul_lat", n, 9);
    check("mul_busy_cycles", busy_n, 8);
    check("mul_out_held", out_ok, 1'b1);
    check("mul_out", Out, 8'h01);
    check("mul_outhi", OutHi, 8'hFE);
    check("mul_zero", Zero, 1'b0);
    check("mul_carry", Carry, 1'b1);
    @(negedge Clk);
    check("mul_ignored_done", Done, 1'b0);
    check("mul_ignored_busy", Busy, 1'b0);
    check("mul_ignored_out", Out, 8'h01);

    // shifts
    do_op(4'd4, 8'h81, 8'd3, 1'b1, lat, busy_n);
    check("lsh_lat", lat, 4);
    check("lsh_busy", busy_n, 3);
    check("lsh_out", Out, 8'h0F);
    check("lsh_outhi", OutHi, 8'h00);
    check("lsh_carry", Carry, 1'b1);
    do_op(4'd6, 8'h80, 8'd7, 1'b0, lat, busy_n);
    check("asr_lat", lat, 8);
    check("asr_out", Out, 8'hFF);
    do_op(4'd5, 8'h80, 8'd0, 1'b0, lat, busy_n);
    check("rsh0_lat", lat, 1);
    check("rsh0_busy", busy_n, 0);
    check("rsh0_out", Out, 8'h80);
    do_op(4'd5, 8'hF0, 8'd2, 1'b0, lat, busy_n);
    check("rsh_out", Out, 8'h3C);

    // async reset during MUL, iteration 4
    @(negedge Clk);
    OP = 4'd10; InputA = 8'd3; InputB = 8'd5; Start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      Start = 1'b0;
    end
    check("pre_rst_busy", Busy, 1'b1);
    #2 Reset = 1'b1;
    #1;
    check("arst_out", Out, 8'h00);
    check("arst_outhi", OutHi, 8'h00);
    check("arst_carry", Carry, 1'b0);
    check("arst_busy", Busy, 1'b0);
    check("arst_done", Done, 1'b0);
    @(negedge Clk);
    Reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      if (Done) seen = 1'b1;
    end
    check("arst_no_done", seen, 1'b0);
    do_op(4'd0, 8'd1, 8'd1, 1'b0, lat, busy_n);
    check("post_rst_add", Out, 8'd2);

    // illegal opcode, then back-to-back XOR on the Done cycle
    do_op(4'd0, 8'hFF, 8'h03, 1'b0, lat, busy_n);
    check("add_wrap_carry", Carry, 1'b1);
    do_op(4'd15, 8'h55, 8'h66, 1'b0, lat, busy_n);
    check("ill_lat", lat, 1);
    check("ill_flag", Illegal, 1'b1);
    check("ill_out", Out, 8'h02);
    check("ill_carry", Carry, 1'b1);
    do_op(4'd7, 8'hF0, 8'hFF, 1'b0, lat, busy_n);
    check("b2b_lat", lat, 1);
    check("xor_out", Out, 8'h0F);
    check("xor_illegal", Illegal, 1'b0);
    check("xor_parity", Parity, 1'b0);
    check("xor_odd", Odd, 1'b1);
    do_op(4'd8, 8'hF0, 8'h3C, 1'b0, lat, busy_n);
    check("and_out", Out, 8'h30);
    do_op(4'd9, 8'hF0, 8'h3C, 1'b0, lat, busy_n);
    check("or_out", Out, 8'hFC);
    check("or_parity", Parity, 1'b0);
    do_op(4'd11, 8'h00, 8'h00, 1'b0, lat, busy_n);
    check("clc_carry", Carry, 1'b0);
    check("clc_out", Out, 8'hFC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
